data_ram_ctrl: RTL
==================

Name: data_ram_ctrl

Overview:
- Data-side memory responder for the MIPS pipeline. It answers the memory stage's ce/we/addr/sel/data requests.
- Holds a word-organised RAM with big-endian byte lanes. sel[3] maps to bits [31:24], which is byte offset 0.
- Returns the full word combinationally on loads; the memory stage extracts the lanes itself.
- After reset it runs a clearing sweep and stalls the pipeline until that sweep is done.

Parameters:
- ADDR_WIDTH, 10: word-index bits. DEPTH = 2**ADDR_WIDTH words.
- CLEAR_ON_RST, 1: 1 = zero every word after reset. 0 = keep contents and go straight to RUN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high (RstEnable = 1).
- ce  in  1  chip enable from the memory stage (ChipEnable = 1).
- we  in  1  write enable (WriteEnable = 1).
- addr  in  32  byte address.
- sel  in  4  byte-lane select; sel[3] = bits [31:24].
- data_i  in  32  store data, already lane-replicated by the requester.
- data_o  out  32  load data, full word.
- ready  out  1  1 = clearing sweep finished.
- stall_req  out  1  pipeline stall request; equals ~ready.
- err_o  out  1  registered one-cycle pulse marking a rejected access.
- load_cnt_o  out  32  load count (optional feature).
- store_cnt_o  out  32  store count (optional feature).

Behaviour:
- Reset values: ready=0, stall_req=1, err_o=0, counters=0, state=CLEAR (RUN if CLEAR_ON_RST=0), clr_cnt=0. While rst=1, data_o=0.
- Word index idx = addr[ADDR_WIDTH+1:2]. The access is out of range if any bit of addr[31:ADDR_WIDTH+2] is 1.
- CLEAR state, per rising edge with rst=0:
  - mem[clr_cnt] <= 0, then clr_cnt++.
  - When clr_cnt == DEPTH-1, go to RUN and set ready=1 on that same edge.
  - ready therefore rises after exactly DEPTH edges with rst=0.
  - During CLEAR: data_o=0, requests are ignored, err_o=0.
- rst=1 at any time returns the block to CLEAR with clr_cnt=0, including mid-sweep.
- RUN, reads (ce=1, we=0):
  - data_o = mem[idx] combinationally, same cycle; sel is ignored.
  - Out-of-range read: data_o=0, and err_o=1 on the next cycle.
- RUN, idle (ce=0): data_o=0, no state change.
- RUN, writes (ce=1, we=1): at the rising edge, each lane i with sel[i]=1 is written from data_i, for example sel[3] writes mem[idx][31:24] <= data_i[31:24].
  - Legal sel/addr[1:0] pairs: 1000/00, 0100/01, 0010/10, 0001/11, 1100/00, 0011/10, 1111/00.
  - Any other pair, sel=0000 included, or an out-of-range address: no lane is written and err_o=1 on the next cycle.
- Read-during-write to the same word is not possible within one request, since one request is one access. A load in cycle N+1 after a store in cycle N sees the new data.
- err_o stays high only for the cycle after the offending request. Back-to-back errors keep it high.
- RAM contents are not reset when CLEAR_ON_RST=0.

Optional Feature:
- Macro DRAM_STATS_EN.
- Defined:
  - load_cnt_o increments on each edge in RUN with ce=1, we=0, in range.
  - store_cnt_o increments on each legal write.
  - Both are 32 bits, wrap from 0xFFFFFFFF to 0, and clear on rst.
- Undefined: both outputs are tied to 0 and no counter logic exists.

Test Plan:
- Reset then idle, DEPTH=1024: stall_req=1 and data_o=0 for 1024 edges; ready=1 and stall_req=0 after the 1024th edge. A load at 0x0 then returns 0x00000000.
- Store 0xDEADBEEF, sel=1111, at 0x10. Load 0x10 → 0xDEADBEEF. Store byte data_i=0x55555555, sel=0100, at 0x11. Load 0x10 → 0xDE55BEEF.
- Halfword 0x12341234 with sel=0011 at 0x22, over a word of 0: load 0x20 → 0x00001234. The same data with sel=1100 at 0x22 is illegal: no write, err_o=1 for exactly one cycle.
- Store to 0x00001000, out of range for ADDR_WIDTH=10: no write, err_o pulses. Load 0x00001000 → data_o=0, err_o pulses. A word at 0x0 written earlier is unchanged.
- Assert rst for 1 cycle at clear count 500, then release: ready rises only after 1024 further edges. Earlier contents read back 0 (CLEAR_ON_RST=1), or are retained with ready=1 one edge after rst (CLEAR_ON_RST=0).
- With DRAM_STATS_EN: 3 loads, 2 legal stores, 1 illegal store → load_cnt_o=3, store_cnt_o=2. Preset via force to 0xFFFFFFFF plus one load → load_cnt_o=0.

Source files
------------

// File: rtl/data_ram_ctrl.sv
// data_ram_ctrl: data-side memory responder for the MIPS memory stage.
// Word-organised RAM with big-endian byte lanes (sel[3] -> bits [31:24], byte offset 0).
// Loads return the full word combinationally. Stores are lane-masked at the rising edge.
// After reset an optional clearing sweep zeroes the RAM, and stall_req holds the pipeline until it is done.
// Optional load/store statistics counters are enabled by defining DRAM_STATS_EN.
module data_ram_ctrl #(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter bit          CLEAR_ON_RST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ready,
  output logic        stall_req,
  output logic        err_o,
  output logic [31:0] load_cnt_o,
  output logic [31:0] store_cnt_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] idx;
  logic                  in_range;
  logic                  sel_ok;
  logic                  rd_req, wr_req;
  logic                  rd_ok, wr_ok;
  logic                  rd_err, wr_err;

  assign idx      = addr[ADDR_WIDTH+1:2];
  assign in_range = ~|addr[31:ADDR_WIDTH+2];

  // Legal lane-select / byte-offset pairs: naturally aligned byte, halfword and word accesses.
  always_comb begin
    sel_ok = 1'b0;
    case ({sel, addr[1:0]})
      6'b1000_00, 6'b0100_01, 6'b0010_10, 6'b0001_11,
      6'b1100_00, 6'b0011_10, 6'b1111_00: sel_ok = 1'b1;
      default:                            sel_ok = 1'b0;
    endcase
  end

  // Request decode; requests are only honoured once the sweep has finished.
  always_comb begin
    rd_req = (state_q == RUN) && ce && !we;
    wr_req = (state_q == RUN) && ce && we;
    rd_ok  = rd_req && in_range;
    wr_ok  = wr_req && in_range && sel_ok;
    rd_err = rd_req && !in_range;
    wr_err = wr_req && !(in_range && sel_ok);
  end

  // Next-state logic: sweep counter, ready flag and error pulse.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ready_d   = ready_q;
    err_d     = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) begin
          state_d = RUN;
          ready_d = 1'b1;
        end
      end
      RUN: begin
        ready_d = 1'b1;
        err_d   = rd_err || wr_err;
      end
      default: begin
        state_d = RUN;
        ready_d = 1'b1;
      end
    endcase
  end

  // Control state registers with synchronous reset back to the sweep start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR_ON_RST ? CLEAR : RUN;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
    end
  end

  // RAM array: zeroed one word per edge during the sweep, lane-masked writes in RUN; contents are never reset directly.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        mem[clr_cnt_q] <= '0;
      end else if (wr_ok) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (sel[i]) begin
            mem[idx][8*i +: 8] <= data_i[8*i +: 8];
          end
        end
      end
    end
  end

  // Combinational load path; zero whenever there is no in-range load in RUN.
  always_comb begin
    data_o = '0;
    if (!rst && rd_ok) begin
      data_o = mem[idx];
    end
  end

  assign ready     = ready_q;
  assign stall_req = ~ready_q;
  assign err_o     = err_q;

`ifdef DRAM_STATS_EN
  logic [31:0] load_cnt_q, load_cnt_d;
  logic [31:0] store_cnt_q, store_cnt_d;

  // Counter increments for accepted loads and legal stores; natural 32-bit wrap.
  always_comb begin
    load_cnt_d  = load_cnt_q;
    store_cnt_d = store_cnt_q;
    if (rd_ok) begin
      load_cnt_d = load_cnt_q + 32'd1;
    end
    if (wr_ok) begin
      store_cnt_d = store_cnt_q + 32'd1;
    end
  end

  // Statistics registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
    end else begin
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
    end
  end

  assign load_cnt_o  = load_cnt_q;
  assign store_cnt_o = store_cnt_q;
`else
  assign load_cnt_o  = '0;
  assign store_cnt_o = '0;
`endif

endmodule
